counter_down_12b: RTL and testbench
===================================

Name: counter_down_12b

Overview:
- Loadable 12-bit down-counter/timer with a terminal-count output, for timeout and interval generation.
- It consumes a count and produces an event; the companion up-counter only produces a count.
- Runs as a small FSM (IDLE/RUN/DONE) with one-shot and auto-reload modes.
- Drives timeouts and periodic ticks for lab-level controllers.

Parameters:
WIDTH, 12, bit width of the count, reload value and b input.
PRESCALE, 4, clocks per decrement when PRESCALER_EN is defined; legal range 2..256; ignored otherwise.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
load  input  1  sync; captures b into reload register and count.
b  input  WIDTH  reload value, sampled when load=1.
start  input  1  sync; begins a count from the reload register.
stop  input  1  sync; aborts a running count.
enable  input  1  count qualifier; when 0 the count holds in RUN.
mode  input  1  0 = one-shot, 1 = auto-reload; sampled every cycle.
c  output  WIDTH  current count, registered.
tc  output  1  terminal-count pulse, exactly one clk wide.
busy  output  1  high in RUN.
done  output  1  high in DONE.

Behaviour:
- Reset (reset=0, async):
  - c=0, reload register=0, state=IDLE.
  - tc=0, busy=0, done=0, prescaler=0.
  - Release is synchronous to clk; first action on the first rising edge with reset=1.
- Command priority per edge: load > stop > start > counting.
- load=1 in any state:
  - reload<=b, c<=b, prescaler<=0, tc<=0.
  - State unchanged: RUN continues from b; DONE stays DONE.
  - start/stop in the same cycle are ignored.
- start=1 in IDLE or DONE:
  - c<=reload.
  - If reload==0: go to DONE and set tc<=1 for one cycle.
  - Otherwise go to RUN.
  - start in RUN is ignored.
- stop=1 in RUN: go to IDLE; c holds its value; no tc.
  - stop in IDLE/DONE: no effect.
- RUN with enable=1 (decrement tick every cycle):
  - c>1: c<=c-1.
  - c==1, mode=0: c<=0, tc<=1, go to DONE.
  - c==1, mode=1: c<=reload, tc<=1, stay RUN. Period = reload cycles per tc.
- RUN with enable=0: c, prescaler and state hold; tc=0.
- tc: registered; high only in the cycle after the edge that produced it. Never high two consecutive cycles except in auto-reload with reload==1 (tc every cycle).
- busy and done decode the state register directly; no added latency.
- Arithmetic: unsigned, WIDTH bits.
  - c never decrements below 0 and never wraps to all-ones.
  - Maximum reload is 2^WIDTH-1 (0xFFF = 4095 cycles).
- mode change during RUN takes effect at the next terminal count.
- Async reset mid-RUN returns to IDLE with c=0; the pending tc is lost.

Optional Feature:
PRESCALER_EN
- Defined:
  - An internal prescaler counts enabled RUN cycles from 0 to PRESCALE-1.
  - A decrement tick occurs only when the prescaler wraps.
  - Prescaler clears on load, start and stop; holds when enable=0.
  - One-shot duration = reload*PRESCALE enabled cycles.
- Not defined: no prescaler logic; every enabled RUN cycle is a tick; PRESCALE is unused.

Test Plan:
- Reset mid-run: load b=0x00A, start, 3 enabled cycles, pull reset=0 between edges -> c=0, busy=0, tc=0 immediately, without waiting for clk.
- One-shot: load b=0x005, start, enable=1, mode=0 -> c steps 5,4,3,2,1,0; tc=1 for exactly one cycle as c reaches 0; done=1 after, busy=0.
- Auto-reload: load b=0x003, mode=1, start, enable held 1 for 12 cycles -> tc pulses 4 times, every 3 cycles; c sequence 3,2,1,3,2,1,...
- enable gating and stop: load b=0x010, start, enable toggled 1/0 -> c decrements only on enable=1 cycles; stop at c=0x009 -> IDLE, c stays 0x009, no tc.
- Boundaries:
  - load b=0x000 then start -> DONE next cycle, tc one pulse.
  - load b=0xFFF, one-shot -> tc after exactly 4095 enabled cycles.
  - load and start in the same cycle -> start ignored, state unchanged.
- PRESCALER_EN with PRESCALE=4: load b=0x002, one-shot -> tc after 8 enabled cycles; disabling enable for 2 cycles mid-count delays tc by 2.

Source files
------------

// File: rtl/counter_down_12b_if.sv
// rtl/counter_down_12b_if.sv - command/status bundle for the loadable down-counter
interface counter_down_12b_if #(
    parameter int WIDTH = 12
);
    logic             load;
    logic [WIDTH-1:0] b;
    logic             start;
    logic             stop;
    logic             enable;
    logic             mode;
    logic [WIDTH-1:0] c;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, b, start, stop, enable, mode,
        input  c, tc, busy, done
    );

    modport slave (
        input  load, b, start, stop, enable, mode,
        output c, tc, busy, done
    );
endinterface

// File: rtl/counter_down_12b.sv
// rtl/counter_down_12b.sv - loadable down-counter/timer with terminal-count pulse
// Optional prescaler on the decrement tick is built when PRESCALER_EN is defined.
module counter_down_12b #(
    parameter int WIDTH    = 12,
    parameter int PRESCALE = 4
) (
    input  logic               clk,
    input  logic               reset,
    counter_down_12b_if.slave  io
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    if (PRESCALE < 2 || PRESCALE > 256) begin : g_prescale_range
        $error("counter_down_12b: PRESCALE must be within 2..256");
    end

    state_t           state_q, state_n;
    logic [WIDTH-1:0] c_q, c_n;
    logic [WIDTH-1:0] reload_q, reload_n;
    logic             tc_q, tc_n;
    logic             tick;

`ifdef PRESCALER_EN
    localparam int          PW      = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_n;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            c_q      <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
`ifdef PRESCALER_EN
            pre_q    <= '0;
`endif
        end else begin
            state_q  <= state_n;
            c_q      <= c_n;
            reload_q <= reload_n;
            tc_q     <= tc_n;
`ifdef PRESCALER_EN
            pre_q    <= pre_n;
`endif
        end
    end

    always_comb begin
        state_n  = state_q;
        c_n      = c_q;
        reload_n = reload_q;
        tc_n     = 1'b0;
`ifdef PRESCALER_EN
        pre_n    = pre_q;
        tick     = (pre_q == PRE_MAX);
`else
        tick     = 1'b1;
`endif

        if (io.load) begin
            reload_n = io.b;
            c_n      = io.b;
`ifdef PRESCALER_EN
            pre_n    = '0;
`endif
        end else if (io.stop && state_q == RUN) begin
            state_n = IDLE;
`ifdef PRESCALER_EN
            pre_n   = '0;
`endif
        end else if (io.start && state_q != RUN) begin
            c_n = reload_q;
`ifdef PRESCALER_EN
            pre_n = '0;
`endif
            if (reload_q == '0) begin
                state_n = DONE;
                tc_n    = 1'b1;
            end else begin
                state_n = RUN;
            end
        end else if (state_q == RUN && io.enable) begin
`ifdef PRESCALER_EN
            pre_n = tick ? '0 : pre_q + 1'b1;
`endif
            if (tick) begin
                if (c_q > ONE) begin
                    c_n = c_q - ONE;
                end else begin
                    // c==0 in RUN (zero loaded mid-run) terminates like c==1 rather than wrapping
                    tc_n = 1'b1;
                    if (io.mode) begin
                        c_n = reload_q;
                    end else begin
                        c_n     = '0;
                        state_n = DONE;
                    end
                end
            end
        end
    end

    assign io.c    = c_q;
    assign io.tc   = tc_q;
    assign io.busy = (state_q == RUN);
    assign io.done = (state_q == DONE);
endmodule

// File: tb/tb_counter_down_12b.sv
// tb/tb_counter_down_12b.sv - scoreboard bench for counter_down_12b
module tb_counter_down_12b;
`ifdef PRESCALER_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    typedef struct packed {
        logic [11:0] c;
        logic        tc;
        logic        busy;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;
    string phase = "init";
    exp_t  exp_q[$];

    int          m_st;
    logic [11:0] m_c;
    logic [11:0] m_rl;
    int          m_pre;
    logic        m_tc;

    counter_down_12b_if #(.WIDTH(12)) io ();

    counter_down_12b dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_c = '0; m_rl = '0; m_pre = 0; m_tc = 1'b0;
    endtask

    task automatic model_next(input logic l, input logic [11:0] bv, input logic s,
                              input logic p, input logic e, input logic m);
        logic tk;
        m_tc = 1'b0;
        if (l) begin
            m_rl = bv; m_c = bv; m_pre = 0;
        end else if (p && m_st == 1) begin
            m_st = 0; m_pre = 0;
        end else if (s && m_st != 1) begin
            m_c = m_rl; m_pre = 0;
            if (m_rl == 0) begin m_st = 2; m_tc = 1'b1; end
            else m_st = 1;
        end else if (m_st == 1 && e) begin
            tk    = (m_pre == PS - 1);
            m_pre = tk ? 0 : m_pre + 1;
            if (tk) begin
                if (m_c > 1) m_c = m_c - 1;
                else begin
                    m_tc = 1'b1;
                    if (m) m_c = m_rl;
                    else begin m_c = 0; m_st = 2; end
                end
            end
        end
    endtask

    task automatic step(input logic l, input logic [11:0] bv, input logic s,
                        input logic p, input logic e, input logic m);
        exp_t x;
        io.load = l; io.b = bv; io.start = s; io.stop = p; io.enable = e; io.mode = m;
        model_next(l, bv, s, p, e, m);
        x = '{c: m_c, tc: m_tc, busy: (m_st == 1), done: (m_st == 2)};
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        check("c",    32'(io.c),    32'(x.c));
        check("tc",   32'(io.tc),   32'(x.tc));
        check("busy", 32'(io.busy), 32'(x.busy));
        check("done", 32'(io.done), 32'(x.done));
    endtask

    task automatic run_to_tc(input int bound, input logic m, output int n);
        n = 0;
        do begin
            step(1'b0, 12'h0, 1'b0, 1'b0, 1'b1, m);
            n++;
        end while (!io.tc && n < bound);
    endtask

    initial begin
        int n;
        int ntc;
        int last;
        int nen;
        logic e;

        reset = 1'b0;
        io.load = 1'b0; io.b = '0; io.start = 1'b0; io.stop = 1'b0;
        io.enable = 1'b0; io.mode = 1'b0;
        model_reset();
        #12;
        phase = "reset";
        check("c", 32'(io.c), 0);
        check("tc", 32'(io.tc), 0);
        check("busy", 32'(io.busy), 0);
        check("done", 32'(io.done), 0);
        #5 reset = 1'b1;

        phase = "async_reset";
        step(1'b1, 12'h00A, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 12'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 12'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("c0", 32'(io.c), 0);
        check("busy0", 32'(io.busy), 0);
        check("tc0", 32'(io.tc), 0);
        check("done0", 32'(io.done), 0);
        model_reset();
        #2 reset = 1'b1;

        phase = "one_shot";
        step(1'b1, 12'h005, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 12'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("start_c", 32'(io.c), 5);
        run_to_tc(5 * PS + 4, 1'b0, n);
        check("len", n, 5 * PS);
        check("end_c", 32'(io.c), 0);
        check("end_done", 32'(io.done), 1);
        check("end_busy", 32'(io.busy), 0);
        step(1'b0, 12'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("tc_once", 32'(io.tc), 0);
        check("stop_in_done", 32'(io.done), 1);

        phase = "auto_reload";
        step(1'b1, 12'h003, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 12'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        ntc = 0; last = 0;
        for (int i = 1; i <= 12 * PS; i++) begin
            step(1'b0, 12'h0, 1'b0, 1'b0, 1'b1, 1'b1);
            if (io.tc) begin
                ntc++;
                check("period", i - last, 3 * PS);
                check("reload_c", 32'(io.c), 3);
                last = i;
            end
        end
        check("tc_count", ntc, 4);
        step(1'b0, 12'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("stopped", 32'(io.busy), 0);

        phase = "gate_stop";
        step(1'b1, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 12'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        nen = 0;
        for (int k = 0; k < 200; k++) begin
            e = (k % 2 == 0);
            step(1'b0, 12'h0, 1'b0, 1'b0, e, 1'b0);
            if (e) nen++;
            if (io.c == 12'h009) break;
        end
        check("en_cycles", nen, 7 * PS);
        step(1'b0, 12'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("stop_c", 32'(io.c), 9);
        check("stop_busy", 32'(io.busy), 0);
        check("stop_tc", 32'(io.tc), 0);
        step(1'b0, 12'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("idle_hold", 32'(io.c), 9);

        phase = "zero";
        step(1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 12'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("z_done", 32'(io.done), 1);
        check("z_tc", 32'(io.tc), 1);
        step(1'b0, 12'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("z_tc_off", 32'(io.tc), 0);

        phase = "load_start";
        step(1'b1, 12'h007, 1'b1, 1'b0, 1'b1, 1'b0);
        check("ls_done", 32'(io.done), 1);
        check("ls_c", 32'(io.c), 7);
        check("ls_busy", 32'(io.busy), 0);

        phase = "gap";
        step(1'b1, 12'h002, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 12'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 12'h0, 1'b0, 1'b0, (i != 1 && i != 2), 1'b0);
            n++;
            if (io.tc) break;
        end
        check("gap_len", n, 2 * PS + 2);

        phase = "max";
        step(1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 12'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_to_tc(4095 * PS + 8, 1'b0, n);
        check("max_len", n, 4095 * PS);
        check("max_done", 32'(io.done), 1);

        phase = "end";
        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
